play_sequencer: RTL and testbench
=================================

PLAY_SEQUENCER -- requirements
Module: play_sequencer

Interface
REQ-001 Parameter NOTE_TICKS, default 25000000, SHALL set clk cycles per note (legal value >=1).
REQ-002 Parameter GAP_TICKS, default 2500000, SHALL set the silent cycles between notes; 0 means no gap.
REQ-003 Parameter MAX_NOTES, default 32, SHALL set notes per song slot (power of 2, >=2).
REQ-004 clk  in  1  system clock; all state SHALL change on its rising edge.
REQ-005 rst  in  1  reset; asynchronous, active-high.
REQ-006 start  in  1  single-cycle request to begin playing song_select.
REQ-007 stop  in  1  single-cycle request to abort playback.
REQ-008 next_song  in  1  single-cycle request to skip to the next song slot.
REQ-009 pause  in  1  level; 1 freezes playback.
REQ-010 loop_en  in  1  level; 1 restarts the song at its end.
REQ-011 song_select  in  2  song slot latched on start.
REQ-012 rom_addr  out  2+log2(MAX_NOTES)  {cur_song, note_idx}, driven from registers.
REQ-013 rom_note  in  4  note code at rom_addr; combinational, same cycle.
REQ-014 rom_last  in  1  1 when rom_addr holds the song's final note.
REQ-015 note_to_play  out  4  registered note code to buzzer; 0 = rest.
REQ-016 playing  out  1  1 in NOTE, GAP or PAUSE.
REQ-017 song_done  out  1  one-cycle pulse at song end.
REQ-018 cur_song  out  2  active song slot.

Function
REQ-019 FSM states SHALL be IDLE, NOTE, GAP, PAUSE; a tick counter and note_idx SHALL accompany it.
REQ-020 Request priority SHALL be stop > next_song > start > pause when several are asserted in one cycle.
REQ-021 IDLE + start: latch song_select into cur_song, note_idx=0, counter=0, go to NOTE; start SHALL be ignored outside IDLE.
REQ-022 NOTE SHALL last exactly NOTE_TICKS cycles; GAP SHALL last exactly GAP_TICKS cycles and SHALL be skipped when GAP_TICKS=0.
REQ-023 note_to_play SHALL load rom_note on every edge where state is NOTE, and 0 otherwise; output lags state by one cycle.
REQ-024 At the last NOTE cycle with rom_last=0: note_idx+1, then enter GAP (or NOTE if GAP_TICKS=0).
REQ-025 At the last NOTE cycle with rom_last=1, or with note_idx=MAX_NOTES-1: pulse song_done; the post-gap target SHALL be NOTE with note_idx=0 when loop_en=1, else IDLE.
REQ-026 loop_en SHALL be sampled at the final note's last NOTE cycle.
REQ-027 pause=1 in NOTE/GAP: enter PAUSE and hold counter, note_idx and the return state; pause=0: resume the held state at the held count.
REQ-028 stop in any state: go to IDLE next edge, clear counter and note_idx, and produce no song_done.
REQ-029 next_song in NOTE/GAP/PAUSE: cur_song+1 mod 4, note_idx=0, counter=0, go to NOTE; ignored in IDLE.
REQ-030 song_select changes SHALL have no effect except at an accepted start.

Reset
REQ-031 rst SHALL immediately force IDLE, note_to_play=0, playing=0, song_done=0, cur_song=0, note_idx=0, counter=0, including during playback.
REQ-032 The first rising edge after rst deasserts SHALL evaluate requests normally.

Structure
REQ-033 State encoding and the note-code width (4) SHALL live in the shared para.v package; the note ROM SHALL be external.
REQ-034 The tick counter SHALL be the sub-module tick_counter (load/hold/terminal-count), sized to max(NOTE_TICKS, GAP_TICKS).

Verification (NOTE_TICKS=4, GAP_TICKS=1, MAX_NOTES=4, ROM slot1 = 3,5,7 with rom_last on index 2)
REQ-035 start with song_select=1 -> note_to_play sequence 3x4,0,5x4,0,7x4,0; song_done high for 1 cycle; playing=0 afterwards.
REQ-036 loop_en=1 with the same stimulus -> after the 7 and the gap, note_to_play returns to 3; playing stays 1.
REQ-037 pause held 3 cycles in the 2nd cycle of note 5 -> output 0 for 3 cycles, then 5 for the remaining 3 cycles.
REQ-038 stop and next_song in the same cycle mid-note -> IDLE, no song_done, cur_song unchanged.
REQ-039 next_song in slot 3 -> cur_song=0, note_idx=0, and slot 0's first note plays.
REQ-040 rst asserted mid-GAP -> all outputs 0 asynchronously; a start after deassertion plays from note_idx 0.

Source files
------------

// File: rtl/play_sequencer_pkg.sv
// Shared types and sizing helpers for the song sequencer.
// The FSM encoding and the note-code width live here so all files agree on them.
package play_sequencer_pkg;

    localparam int NOTE_W = 4;
    localparam int SONG_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_NOTE  = 2'd1,
        ST_GAP   = 2'd2,
        ST_PAUSE = 2'd3
    } state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // A counter that must reach ticks-1 needs clog2(ticks) bits, never fewer than one.
    function automatic int cnt_width(input int ticks);
        return (ticks > 1) ? $clog2(ticks) : 1;
    endfunction

endpackage

// File: rtl/play_sequencer_if.sv
// Note ROM lookup bus: the sequencer presents an address, the ROM answers
// combinationally with the note code and an end-of-song flag.
interface play_sequencer_if
    import play_sequencer_pkg::*;
#(
    parameter int ADDR_W = 7
);
    logic [ADDR_W-1:0] rom_addr;
    logic [NOTE_W-1:0] rom_note;
    logic              rom_last;

    modport master (output rom_addr, input rom_note, input rom_last);
    modport slave  (input rom_addr, output rom_note, output rom_last);
endinterface

// File: rtl/play_sequencer_tick_counter.sv
// Up-counter with synchronous load, hold, and a terminal-count compare
// against a caller-supplied last value.
module tick_counter #(
    parameter int W = 25
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         hold,
    input  logic [W-1:0] load_val,
    input  logic [W-1:0] tc_val,
    output logic         tc
);
    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Load wins over hold; otherwise count up by one
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (hold) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Count register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= {W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == tc_val);

endmodule

// File: rtl/play_sequencer.sv
// Steps through a song slot of an external note ROM, holding each note for
// NOTE_TICKS cycles with GAP_TICKS of silence between notes.
module play_sequencer
    import play_sequencer_pkg::*;
#(
    parameter int NOTE_TICKS = 25000000,
    parameter int GAP_TICKS  = 2500000,
    parameter int MAX_NOTES  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              next_song,
    input  logic              pause,
    input  logic              loop_en,
    input  logic [SONG_W-1:0] song_select,
    play_sequencer_if.master  rom,
    output logic [NOTE_W-1:0] note_to_play,
    output logic              playing,
    output logic              song_done,
    output logic [SONG_W-1:0] cur_song
);
    localparam int IDX_W = $clog2(MAX_NOTES);
    localparam int CNT_W = cnt_width(max_int(NOTE_TICKS, GAP_TICKS));
    localparam logic [CNT_W-1:0] NOTE_LAST = CNT_W'(NOTE_TICKS - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_TICKS > 0) ? (GAP_TICKS - 1) : 0);
    localparam logic [IDX_W-1:0] IDX_MAX   = IDX_W'(MAX_NOTES - 1);

    state_e              state_q, state_d;
    state_e              ret_q, ret_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [SONG_W-1:0]   song_q, song_d;
    logic                final_q, final_d;   // current gap follows the song's last note
    logic                loop_q, loop_d;     // loop_en captured at that last note
    logic [NOTE_W-1:0]   note_q, note_d;
    logic                playing_q, playing_d;
    logic                done_q, done_d;

    logic                cnt_load_s;
    logic                cnt_hold_s;
    logic [CNT_W-1:0]    tc_val_s;
    logic                tc_s;

    tick_counter #(.W(CNT_W)) u_tick (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load_s),
        .hold     (cnt_hold_s),
        .load_val ({CNT_W{1'b0}}),
        .tc_val   (tc_val_s),
        .tc       (tc_s)
    );

    // Terminal value depends on which segment is being timed
    always_comb begin
        tc_val_s = NOTE_LAST;
        if (state_q == ST_GAP) begin
            tc_val_s = GAP_LAST;
        end else begin
            tc_val_s = NOTE_LAST;
        end
    end

    // Next-state and request handling: stop > next_song > start > pause
    always_comb begin
        state_d    = state_q;
        ret_d      = ret_q;
        idx_d      = idx_q;
        song_d     = song_q;
        final_d    = final_q;
        loop_d     = loop_q;
        done_d     = 1'b0;
        cnt_load_s = 1'b0;
        cnt_hold_s = 1'b0;

        if (stop) begin
            state_d    = ST_IDLE;
            idx_d      = {IDX_W{1'b0}};
            final_d    = 1'b0;
            cnt_load_s = 1'b1;
        end else if (next_song && (state_q != ST_IDLE)) begin
            state_d    = ST_NOTE;
            song_d     = song_q + SONG_W'(1);
            idx_d      = {IDX_W{1'b0}};
            final_d    = 1'b0;
            cnt_load_s = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d    = ST_NOTE;
                        song_d     = song_select;
                        idx_d      = {IDX_W{1'b0}};
                        cnt_load_s = 1'b1;
                    end else begin
                        cnt_hold_s = 1'b1;
                    end
                end
                ST_NOTE: begin
                    if (pause) begin
                        state_d    = ST_PAUSE;
                        ret_d      = ST_NOTE;
                        cnt_hold_s = 1'b1;
                    end else if (tc_s) begin
                        cnt_load_s = 1'b1;
                        if (rom.rom_last || (idx_q == IDX_MAX)) begin
                            done_d = 1'b1;
                            idx_d  = {IDX_W{1'b0}};
                            if (GAP_TICKS > 0) begin
                                state_d = ST_GAP;
                                final_d = 1'b1;
                                loop_d  = loop_en;
                            end else begin
                                state_d = loop_en ? ST_NOTE : ST_IDLE;
                            end
                        end else begin
                            idx_d   = idx_q + IDX_W'(1);
                            final_d = 1'b0;
                            state_d = (GAP_TICKS > 0) ? ST_GAP : ST_NOTE;
                        end
                    end else begin
                        cnt_hold_s = 1'b0;
                    end
                end
                ST_GAP: begin
                    if (pause) begin
                        state_d    = ST_PAUSE;
                        ret_d      = ST_GAP;
                        cnt_hold_s = 1'b1;
                    end else if (tc_s) begin
                        cnt_load_s = 1'b1;
                        final_d    = 1'b0;
                        if (final_q && !loop_q) begin
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_NOTE;
                        end
                    end else begin
                        cnt_hold_s = 1'b0;
                    end
                end
                ST_PAUSE: begin
                    cnt_hold_s = 1'b1;
                    if (!pause) begin
                        state_d = ret_q;
                    end else begin
                        state_d = ST_PAUSE;
                    end
                end
                default: begin
                    state_d    = ST_IDLE;
                    idx_d      = {IDX_W{1'b0}};
                    cnt_load_s = 1'b1;
                end
            endcase
        end
    end

    // Output values registered alongside the state; the note lags the state by one cycle
    always_comb begin
        note_d    = {NOTE_W{1'b0}};
        playing_d = (state_d != ST_IDLE);
        if (state_q == ST_NOTE) begin
            note_d = rom.rom_note;
        end else begin
            note_d = {NOTE_W{1'b0}};
        end
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            ret_q     <= ST_NOTE;
            idx_q     <= {IDX_W{1'b0}};
            song_q    <= {SONG_W{1'b0}};
            final_q   <= 1'b0;
            loop_q    <= 1'b0;
            note_q    <= {NOTE_W{1'b0}};
            playing_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ret_q     <= ret_d;
            idx_q     <= idx_d;
            song_q    <= song_d;
            final_q   <= final_d;
            loop_q    <= loop_d;
            note_q    <= note_d;
            playing_q <= playing_d;
            done_q    <= done_d;
        end
    end

    assign rom.rom_addr = {song_q, idx_q};
    assign note_to_play = note_q;
    assign playing      = playing_q;
    assign song_done    = done_q;
    assign cur_song     = song_q;

endmodule

// File: tb/tb_play_sequencer.sv
// Bench for play_sequencer: fixed vectors for the documented scenarios, then
// random requests compared against a countdown-based reference model.
module tb_play_sequencer;
    localparam int NT = 4;
    localparam int GT = 1;
    localparam int MN = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0, stop = 1'b0, next_song = 1'b0, pause = 1'b0, loop_en = 1'b0;
    logic [1:0] song_select = 2'd0;
    logic [3:0] note_to_play;
    logic       playing, song_done;
    logic [1:0] cur_song;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [3:0] rom_mem      [16];
    logic       rom_last_mem [16];

    play_sequencer_if #(.ADDR_W(4)) rom_if ();

    play_sequencer #(.NOTE_TICKS(NT), .GAP_TICKS(GT), .MAX_NOTES(MN)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .stop         (stop),
        .next_song    (next_song),
        .pause        (pause),
        .loop_en      (loop_en),
        .song_select  (song_select),
        .rom          (rom_if),
        .note_to_play (note_to_play),
        .playing      (playing),
        .song_done    (song_done),
        .cur_song     (cur_song)
    );

    always #5 clk = ~clk;

    always_comb begin
        rom_if.rom_note = rom_mem[rom_if.rom_addr];
        rom_if.rom_last = rom_last_mem[rom_if.rom_addr];
    end

    // Reference model: a song is playing or not; each segment counts down its remaining cycles
    int         m_active, m_gap, m_paused, m_rem, m_song, m_idx, m_pend;
    logic [3:0] m_note;
    logic       m_done;

    task automatic model_reset();
        m_active = 0; m_gap = 0; m_paused = 0; m_rem = 0;
        m_song = 0; m_idx = 0; m_pend = 0; m_note = 4'd0; m_done = 1'b0;
    endtask

    task automatic model_end_segment();
        if (m_pend == 2) m_active = 0;
        else m_rem = NT;
        m_pend = 0;
    endtask

    task automatic model_step();
        logic [3:0] nn;
        logic       dd;
        nn = (m_active != 0 && m_paused == 0 && m_gap == 0) ? rom_mem[m_song*4 + m_idx] : 4'd0;
        dd = 1'b0;
        if (stop) begin
            m_active = 0; m_paused = 0; m_gap = 0; m_idx = 0; m_pend = 0;
        end else if (next_song && m_active != 0) begin
            m_song = (m_song + 1) % 4; m_idx = 0; m_gap = 0; m_paused = 0; m_pend = 0; m_rem = NT;
        end else if (m_active == 0) begin
            if (start) begin
                m_active = 1; m_song = int'(song_select); m_idx = 0; m_gap = 0; m_rem = NT;
            end
        end else if (m_paused != 0) begin
            if (!pause) m_paused = 0;
        end else if (pause) begin
            m_paused = 1;
        end else begin
            m_rem = m_rem - 1;
            if (m_rem == 0) begin
                if (m_gap == 0) begin
                    if (rom_last_mem[m_song*4 + m_idx] || m_idx == MN - 1) begin
                        dd = 1'b1; m_idx = 0; m_pend = loop_en ? 1 : 2;
                    end else begin
                        m_idx = m_idx + 1; m_pend = 0;
                    end
                    if (GT > 0) begin
                        m_gap = 1; m_rem = GT;
                    end else begin
                        model_end_segment();
                    end
                end else begin
                    m_gap = 0;
                    model_end_segment();
                end
            end
        end
        m_note = nn;
        m_done = dd;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Apply one set of inputs across a rising edge; returns at the following falling edge
    task automatic step(input logic st, input logic sp, input logic nx, input logic pz,
                        input logic lp, input logic [1:0] sel);
        start = st; stop = sp; next_song = nx; pause = pz; loop_en = lp; song_select = sel;
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        start = 1'b0; stop = 1'b0; next_song = 1'b0; pause = 1'b0; loop_en = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    typedef struct {
        logic       st;
        logic       lp;
        logic [1:0] sel;
        logic [3:0] note;
        logic       done;
        logic       play;
    } vec_t;

    vec_t tbl [17];

    initial begin
        logic [3:0] exp_notes [17];
        logic       saw_done;
        logic       pz_lvl, lp_lvl;

        for (int i = 0; i < 16; i++) begin
            rom_mem[i] = 4'd15; rom_last_mem[i] = 1'b0;
        end
        rom_mem[0] = 4'd1;  rom_mem[1] = 4'd2;  rom_mem[2] = 4'd4;  rom_mem[3] = 4'd8;
        rom_mem[4] = 4'd3;  rom_mem[5] = 4'd5;  rom_mem[6] = 4'd7;  rom_last_mem[6] = 1'b1;
        rom_mem[8] = 4'd9;  rom_mem[9] = 4'd10; rom_last_mem[9] = 1'b1;
        rom_mem[12] = 4'd11; rom_mem[13] = 4'd12; rom_mem[14] = 4'd13; rom_mem[15] = 4'd14;
        rom_last_mem[15] = 1'b1;

        exp_notes = '{4'd0, 4'd3, 4'd3, 4'd3, 4'd3, 4'd0, 4'd5, 4'd5, 4'd5, 4'd5,
                      4'd0, 4'd7, 4'd7, 4'd7, 4'd7, 4'd0, 4'd0};
        for (int k = 0; k < 17; k++) begin
            tbl[k] = '{st: (k == 0), lp: 1'b0, sel: 2'd1, note: exp_notes[k],
                       done: (k == 14), play: (k <= 14)};
        end

        // Reset state
        do_reset();
        chk("reset_note", 32'(note_to_play), 32'd0);
        chk("reset_playing", 32'(playing), 32'd0);
        chk("reset_done", 32'(song_done), 32'd0);
        chk("reset_song", 32'(cur_song), 32'd0);
        chk("reset_addr", 32'(rom_if.rom_addr), 32'd0);

        // Whole song from slot 1
        for (int k = 0; k < 17; k++) begin
            step(tbl[k].st, 1'b0, 1'b0, 1'b0, tbl[k].lp, tbl[k].sel);
            chk($sformatf("song_note[%0d]", k), 32'(note_to_play), 32'(tbl[k].note));
            chk($sformatf("song_done[%0d]", k), 32'(song_done), 32'(tbl[k].done));
            chk($sformatf("song_play[%0d]", k), 32'(playing), 32'(tbl[k].play));
        end

        // Looping restarts at note 0 after the final gap
        do_reset();
        for (int k = 0; k < 18; k++) begin
            step(k == 0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1);
            if (k == 14) chk("loop_done", 32'(song_done), 32'd1);
            if (k == 15) begin
                chk("loop_gap_note", 32'(note_to_play), 32'd0);
                chk("loop_playing", 32'(playing), 32'd1);
                chk("loop_addr", 32'(rom_if.rom_addr), 32'd4);
            end
            if (k >= 16) chk($sformatf("loop_note[%0d]", k), 32'(note_to_play), 32'd3);
        end

        // Pause held for three cycles in the second cycle of note 5
        do_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1);
        exp_notes = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd5, 4'd5, 4'd0, 4'd0,
                      4'd0, 4'd5, 4'd5, 4'd5, 4'd0, 4'd0, 4'd0};
        for (int k = 1; k <= 14; k++) begin
            step(1'b0, 1'b0, 1'b0, (k >= 7 && k <= 9), 1'b0, 2'd1);
            if (k >= 6) chk($sformatf("pause_note[%0d]", k), 32'(note_to_play), 32'(exp_notes[k]));
            if (k >= 8 && k <= 10) chk($sformatf("pause_play[%0d]", k), 32'(playing), 32'd1);
        end

        // stop beats next_song in the same cycle
        do_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd1);
        chk("stopnext_playing", 32'(playing), 32'd0);
        chk("stopnext_song", 32'(cur_song), 32'd1);
        saw_done = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2);
            if (song_done) saw_done = 1'b1;
        end
        chk("stopnext_no_done", 32'(saw_done), 32'd0);
        chk("stopnext_idle_note", 32'(note_to_play), 32'd0);

        // next_song wraps slot 3 to slot 0
        do_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd3);
        chk("wrap_song", 32'(cur_song), 32'd0);
        chk("wrap_addr", 32'(rom_if.rom_addr), 32'd0);
        chk("wrap_old_note", 32'(note_to_play), 32'd11);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3);
        chk("wrap_new_note", 32'(note_to_play), 32'd1);

        // Asynchronous reset in the middle of a gap
        do_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1);
        for (int k = 1; k <= 4; k++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1);
        chk("gap_before_rst_note", 32'(note_to_play), 32'd3);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_note", 32'(note_to_play), 32'd0);
        chk("async_rst_playing", 32'(playing), 32'd0);
        chk("async_rst_song", 32'(cur_song), 32'd0);
        chk("async_rst_addr", 32'(rom_if.rom_addr), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1);
        chk("after_rst_addr", 32'(rom_if.rom_addr), 32'd4);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1);
        chk("after_rst_note", 32'(note_to_play), 32'd3);

        // Random requests against the reference model
        do_reset();
        pz_lvl = 1'b0;
        lp_lvl = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) pz_lvl = ~pz_lvl;
            if ($urandom_range(0, 39) == 0) lp_lvl = ~lp_lvl;
            step($urandom_range(0, 9) == 0, $urandom_range(0, 79) == 0,
                 $urandom_range(0, 49) == 0, pz_lvl, lp_lvl, 2'($urandom_range(0, 3)));
            chk("rnd_note", 32'(note_to_play), 32'(m_note));
            chk("rnd_done", 32'(song_done), 32'(m_done));
            chk("rnd_playing", 32'(playing), 32'(m_active != 0));
            chk("rnd_song", 32'(cur_song), 32'(m_song));
            chk("rnd_addr", 32'(rom_if.rom_addr), 32'(m_song*4 + m_idx));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
